// File: rtl/dnoc_itf_in_c_channel.sv
// Destination-side receiver for NoC c-channel head flits: filters by target ID,
// buffers in a 2-entry FIFO, and dispatches in order to read-engine / core / DMA.
module dnoc_itf_in_c_channel #(
    parameter logic [3:0] NODE_ID = 4'd0,
    parameter logic [3:0] DMA_ID  = 4'b1101
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] out_flit,
    input  logic         out_last,
    input  logic         out_valid,
    output logic         out_ready,
    output logic         rd_req_valid,
    input  logic         rd_req_ready,
    output logic [255:0] rd_req_hdr,
    output logic [24:0]  rd_req_base_addr,
    output logic [12:0]  rd_req_ping_len,
    output logic         rd_req_pp_en,
    output logic [10:0]  rd_req_pp_num,
    output logic [11:0]  rd_req_ret_id,
    output logic         rd_req_mc,
    output logic [11:0]  rd_req_sync_target,
    output logic         rd_req_to_dma,
    output logic         core_resp_valid,
    input  logic         core_resp_ready,
    output logic         dma_resp_valid,
    input  logic         dma_resp_ready,
    output logic [24:0]  resp_base_addr,
    output logic [12:0]  resp_len,
    output logic         err_pulse,
    output logic [7:0]   err_cnt,
    output logic [1:0]   dbg_state_o
);

    // Handshake: a transfer happens on a port in a cycle where valid & ready are
    // both high at the rising edge; valid never depends on ready of the same port.

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [255:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic         err_pulse_q;
    logic [7:0]   err_cnt_q;

    logic         not_empty;
    logic [255:0] head;
    logic         flit_ok, accept, push, drop, pop;

    assign not_empty = (state_q != S_EMPTY);
    assign head      = not_empty ? mem_q[rd_ptr_q] : '0;

    assign out_ready = (state_q != S_FULL);
    assign accept    = out_valid & out_ready;
    assign flit_ok   = out_last & (out_flit[3:0] == NODE_ID);
    assign push      = accept & flit_ok;
    assign drop      = accept & ~flit_ok;

    assign rd_req_valid    = not_empty & ~head[4];
    assign core_resp_valid = not_empty & head[4] & ~head[5];
    assign dma_resp_valid  = not_empty & head[4] & head[5];

    // Only the selected consumer can pop; readies on other ports are ignored.
    assign pop = (rd_req_valid & rd_req_ready)
               | (core_resp_valid & core_resp_ready)
               | (dma_resp_valid & dma_resp_ready);

    assign rd_req_hdr         = head;
    assign rd_req_base_addr   = head[43:19];
    assign rd_req_ping_len    = head[81:69];
    assign rd_req_pp_en       = head[57];
    assign rd_req_pp_num      = head[68:58];
    assign rd_req_ret_id      = head[18:7];
    assign rd_req_mc          = head[6];
    assign rd_req_sync_target = head[210:199];
    assign rd_req_to_dma      = not_empty & (head[10:7] == DMA_ID);
    assign resp_base_addr     = head[43:19];
    assign resp_len           = head[198:186];

    assign err_pulse   = err_pulse_q;
    assign err_cnt     = err_cnt_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (push) state_d = S_ONE;
            S_ONE: begin
                if (push && !pop)      state_d = S_FULL;
                else if (pop && !push) state_d = S_EMPTY;
            end
            S_FULL:  if (pop) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_q ^ push;
            rd_ptr_q    <= rd_ptr_q ^ pop;
            err_pulse_q <= drop;
            if (drop && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Storage is not reset; outputs are masked by not_empty instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= out_flit;
    end

endmodule

// File: tb/tb_dnoc_itf_in_c_channel.sv
// Bench for dnoc_itf_in_c_channel: directed steps plus random traffic, checked
// against a queue-based model of the receive buffer and drop counter.
module tb_dnoc_itf_in_c_channel;

    localparam logic [3:0] NODE_ID = 4'd0;
    localparam logic [3:0] DMA_ID  = 4'b1101;

    logic         clk, rst_n;
    logic [255:0] out_flit;
    logic         out_last, out_valid, out_ready;
    logic         rd_req_valid, rd_req_ready;
    logic [255:0] rd_req_hdr;
    logic [24:0]  rd_req_base_addr;
    logic [12:0]  rd_req_ping_len;
    logic         rd_req_pp_en;
    logic [10:0]  rd_req_pp_num;
    logic [11:0]  rd_req_ret_id;
    logic         rd_req_mc;
    logic [11:0]  rd_req_sync_target;
    logic         rd_req_to_dma;
    logic         core_resp_valid, core_resp_ready;
    logic         dma_resp_valid, dma_resp_ready;
    logic [24:0]  resp_base_addr;
    logic [12:0]  resp_len;
    logic         err_pulse;
    logic [7:0]   err_cnt;
    logic [1:0]   dbg_state_o;

    dnoc_itf_in_c_channel #(.NODE_ID(NODE_ID), .DMA_ID(DMA_ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_hdr(rd_req_hdr),
        .rd_req_base_addr(rd_req_base_addr), .rd_req_ping_len(rd_req_ping_len),
        .rd_req_pp_en(rd_req_pp_en), .rd_req_pp_num(rd_req_pp_num),
        .rd_req_ret_id(rd_req_ret_id), .rd_req_mc(rd_req_mc),
        .rd_req_sync_target(rd_req_sync_target), .rd_req_to_dma(rd_req_to_dma),
        .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
        .dma_resp_valid(dma_resp_valid), .dma_resp_ready(dma_resp_ready),
        .resp_base_addr(resp_base_addr), .resp_len(resp_len),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .dbg_state_o(dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: buffered flits in arrival order, drop counter and pending pulse.
    logic [255:0] exp_q[$];
    int           exp_cnt;
    bit           exp_pulse;
    bit           acc_c, drop_c, pop_c;
    int           n_vec, n_err;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] mk(input logic [3:0] tgt, input logic b4, input logic b5);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
        f[3:0] = tgt;
        f[4]   = b4;
        f[5]   = b5;
        if ($urandom_range(0, 3) == 0) f[10:7] = DMA_ID;
        return f;
    endfunction

    task automatic check_outputs();
        logic [255:0] h;
        bit ne;
        ne = (exp_q.size() > 0);
        h  = ne ? exp_q[0] : '0;
        chk("out_ready", out_ready, exp_q.size() < 2);
        chk("dbg_state", dbg_state_o, exp_q.size());
        chk("rd_req_valid", rd_req_valid, ne && !h[4]);
        chk("core_resp_valid", core_resp_valid, ne && h[4] && !h[5]);
        chk("dma_resp_valid", dma_resp_valid, ne && h[4] && h[5]);
        chk("err_pulse", err_pulse, exp_pulse);
        chk("err_cnt", err_cnt, exp_cnt);
        if (ne) begin
            chk("rd_req_hdr", rd_req_hdr, h);
            chk("rd_req_base_addr", rd_req_base_addr, h[43:19]);
            chk("rd_req_ping_len", rd_req_ping_len, h[81:69]);
            chk("rd_req_pp_en", rd_req_pp_en, h[57]);
            chk("rd_req_pp_num", rd_req_pp_num, h[68:58]);
            chk("rd_req_ret_id", rd_req_ret_id, h[18:7]);
            chk("rd_req_mc", rd_req_mc, h[6]);
            chk("rd_req_sync_target", rd_req_sync_target, h[210:199]);
            chk("rd_req_to_dma", rd_req_to_dma, h[10:7] == DMA_ID);
            chk("resp_base_addr", resp_base_addr, h[43:19]);
            chk("resp_len", resp_len, h[198:186]);
        end
    endtask

    // Drive inputs mid-cycle, check outputs, and precompute this cycle's handshakes.
    task automatic drive(input logic v, input logic [255:0] f, input logic l,
                         input logic rr, input logic cr, input logic dr);
        logic [255:0] h;
        bit ne;
        @(negedge clk);
        out_valid = v; out_flit = f; out_last = l;
        rd_req_ready = rr; core_resp_ready = cr; dma_resp_ready = dr;
        #1;
        check_outputs();
        ne     = (exp_q.size() > 0);
        h      = ne ? exp_q[0] : '0;
        acc_c  = v && (exp_q.size() < 2);
        drop_c = acc_c && !(l && f[3:0] == NODE_ID);
        pop_c  = ne && ((!h[4] && rr) || (h[4] && !h[5] && cr) || (h[4] && h[5] && dr));
    endtask

    task automatic commit();
        @(posedge clk);
        if (pop_c) void'(exp_q.pop_front());
        if (acc_c && !drop_c) exp_q.push_back(out_flit);
        exp_pulse = drop_c;
        if (drop_c && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic cyc(input logic v, input logic [255:0] f, input logic l,
                       input logic rr, input logic cr, input logic dr);
        drive(v, f, l, rr, cr, dr);
        commit();
    endtask

    logic [255:0] f, g, fl[3];

    initial begin
        n_vec = 0; n_err = 0; exp_cnt = 0; exp_pulse = 0;
        rst_n = 1'b0; out_valid = 0; out_flit = '0; out_last = 0;
        rd_req_ready = 0; core_resp_ready = 0; dma_resp_ready = 0;
        #12;
        chk("rst_out_ready", out_ready, 1'b1);
        chk("rst_rd_valid", rd_req_valid, 1'b0);
        chk("rst_core_valid", core_resp_valid, 1'b0);
        chk("rst_dma_valid", dma_resp_valid, 1'b0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_hdr", rd_req_hdr, 256'd0);
        chk("rst_resp_len", resp_len, 13'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read request, visible the cycle after acceptance.
        f = mk(NODE_ID, 1'b0, 1'b0);
        f[43:19] = 25'h0_1234;
        f[81:69] = 13'd64;
        cyc(1, f, 1, 1, 0, 0);
        drive(0, '0, 0, 1, 0, 0);
        chk("t1_valid", rd_req_valid, 1'b1);
        chk("t1_base", rd_req_base_addr, 25'h0_1234);
        chk("t1_len", rd_req_ping_len, 13'd64);
        commit();
        drive(0, '0, 0, 1, 0, 0);
        chk("t1_empty", rd_req_valid, 1'b0);
        commit();

        // Core then DMA response, back to back.
        f = mk(NODE_ID, 1'b1, 1'b0); f[198:186] = 13'd32;
        g = mk(NODE_ID, 1'b1, 1'b1); g[198:186] = 13'd32;
        cyc(1, f, 1, 1, 1, 1);
        drive(1, g, 1, 1, 1, 1);
        chk("t2_core", core_resp_valid, 1'b1);
        chk("t2_core_len", resp_len, 13'd32);
        commit();
        drive(0, '0, 0, 1, 1, 1);
        chk("t2_dma", dma_resp_valid, 1'b1);
        chk("t2_dma_len", resp_len, 13'd32);
        commit();
        cyc(0, '0, 0, 1, 1, 1);

        // Backpressure: third flit held by the router until space frees.
        for (int k = 0; k < 3; k++) fl[k] = mk(NODE_ID, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1, fl[k], 1, 0, 1, 1);
            chk("t3_ready", out_ready, k < 2);
            commit();
        end
        drive(1, fl[2], 1, 1, 0, 0);
        chk("t3_first", rd_req_hdr, fl[0]);
        chk("t3_held", out_ready, 1'b0);
        commit();
        drive(1, fl[2], 1, 1, 0, 0);
        chk("t3_second", rd_req_hdr, fl[1]);
        chk("t3_reopen", out_ready, 1'b1);
        commit();
        drive(0, '0, 0, 1, 0, 0);
        chk("t3_third", rd_req_hdr, fl[2]);
        commit();
        cyc(0, '0, 0, 1, 1, 1);

        // Wrong target and last=0: both dropped.
        cyc(1, mk(NODE_ID + 4'd1, 1'b0, 1'b0), 1, 1, 1, 1);
        drive(1, mk(NODE_ID, 1'b0, 1'b0), 0, 1, 1, 1);
        chk("t4_pulse1", err_pulse, 1'b1);
        chk("t4_novalid", rd_req_valid, 1'b0);
        commit();
        drive(0, '0, 0, 1, 1, 1);
        chk("t4_pulse2", err_pulse, 1'b1);
        chk("t4_cnt", err_cnt, 8'd2);
        commit();

        // Saturation after 300 drops.
        for (int k = 0; k < 300; k++)
            cyc(1, mk(4'($urandom_range(1, 15)), 1'b0, 1'b0), 1, 1, 1, 1);
        cyc(0, '0, 0, 1, 1, 1);
        drive(0, '0, 0, 1, 1, 1);
        chk("t5_sat", err_cnt, 8'd255);
        commit();

        // Asynchronous reset with the FIFO full.
        cyc(1, mk(NODE_ID, 1'b0, 1'b0), 1, 0, 0, 0);
        cyc(1, mk(NODE_ID, 1'b0, 1'b0), 1, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        chk("t6_full", out_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rd_valid", rd_req_valid, 1'b0);
        chk("t6_core_valid", core_resp_valid, 1'b0);
        chk("t6_dma_valid", dma_resp_valid, 1'b0);
        chk("t6_cnt", err_cnt, 8'd0);
        exp_q.delete(); exp_cnt = 0; exp_pulse = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 0, 1, 1, 1);
            chk("t6_ready", out_ready, 1'b1);
            chk("t6_gone", rd_req_valid | core_resp_valid | dma_resp_valid, 1'b0);
            commit();
        end

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] tgt;
            tgt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : NODE_ID;
            cyc(1'($urandom_range(0, 1)), mk(tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
                1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 4; k++) cyc(0, '0, 0, 1, 1, 1);
        drive(0, '0, 0, 1, 1, 1);
        chk("drain_empty", dbg_state_o, 2'd0);
        commit();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
